// File: rtl/fu_share_arbiter_pkg.sv
// Shared types for the functional-unit share arbiter: FSM state encoding,
// performance-counter width and a saturating increment helper.
package fu_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY  = 2'd1,
      DRAIN = 2'd2
   } fu_arb_state_e;

   localparam int PERF_W = 32;

   function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
      return (&v) ? v : v + PERF_W'(1);
   endfunction

endpackage

// File: rtl/fu_share_arbiter_if.sv
// Issue-queue / functional-unit / writeback bundle around the share arbiter.
// The arbiter is the slave side; the surrounding pipeline (or a bench) is the master.
interface fu_share_arbiter_if #(
   parameter int N     = 4,
   parameter int TAG_W = 6
);
   localparam int IDX_W = $clog2(N);

   logic [N-1:0]            req_valid;
   logic [N-1:0][TAG_W-1:0] req_tag;
   logic [N-1:0]            req_ready;
   logic                    fu_start;
   logic [TAG_W-1:0]        fu_tag;
   logic [IDX_W-1:0]        fu_src;
   logic                    fu_done;
   logic                    flush;
   logic                    res_valid;
   logic [TAG_W-1:0]        res_tag;
   logic                    busy;

   modport slave (
      input  req_valid, req_tag, fu_done, flush,
      output req_ready, fu_start, fu_tag, fu_src, res_valid, res_tag, busy
   );

   modport master (
      output req_valid, req_tag, fu_done, flush,
      input  req_ready, fu_start, fu_tag, fu_src, res_valid, res_tag, busy
   );
endinterface

// File: rtl/fu_share_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request bit at or above ptr,
// wrapping from N-1 back to 0.
module rr_picker #(
   parameter  int N     = 4,
   localparam int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] idx,
   output logic             any_valid
);

   logic [IDX_W:0] pos;

   // NOTE: every output of a combinational block is given a default before any
   // conditional assignment, so no path leaves a value held and no latch is inferred.
   always_comb begin
      grant     = '0;
      idx       = '0;
      any_valid = 1'b0;
      pos       = '0;
      for (int k = 0; k < N; k++) begin
         pos = {1'b0, ptr} + (IDX_W+1)'(k);
         if (pos >= (IDX_W+1)'(N)) pos = pos - (IDX_W+1)'(N);
         if (!any_valid && req[pos[IDX_W-1:0]]) begin
            any_valid              = 1'b1;
            grant[pos[IDX_W-1:0]]  = 1'b1;
            idx                    = pos[IDX_W-1:0];
         end
      end
   end

endmodule

// File: rtl/fu_share_arbiter.sv
// Round-robin arbiter sharing one multi-cycle functional unit among N requesters,
// with flush squashing. Optional counters enabled by defining FU_ARB_PERF_EN.
module fu_share_arbiter
   import fu_arb_pkg::*;
#(
   parameter int N     = 4,
   parameter int TAG_W = 6
) (
   input  logic                       clk,
   input  logic                       rstn,
   fu_share_arbiter_if.slave          bus
`ifdef FU_ARB_PERF_EN
   ,
   output logic [N-1:0][PERF_W-1:0]   perf_grant_cnt,
   output logic [PERF_W-1:0]          perf_busy_cnt
`endif
);

   localparam int IDX_W = $clog2(N);

   fu_arb_state_e    state_q, state_d;
   logic [IDX_W-1:0] rr_ptr_q;
   logic [TAG_W-1:0] held_tag_q;
   logic             res_valid_q;
   logic [TAG_W-1:0] res_tag_q;

   logic [N-1:0]     pick_grant;
   logic [IDX_W-1:0] pick_idx;
   logic             pick_any;
   logic             grant_en;
   logic             grant;
   logic             res_valid_d;

   rr_picker #(.N(N)) u_picker (
      .req       (bus.req_valid),
      .ptr       (rr_ptr_q),
      .grant     (pick_grant),
      .idx       (pick_idx),
      .any_valid (pick_any)
   );

   // Launch is held off while in reset so no combinational grant leaks out.
   assign grant_en    = rstn && !bus.flush &&
                        (state_q == IDLE || (state_q == BUSY && bus.fu_done));
   assign grant       = grant_en && pick_any;
   assign res_valid_d = (state_q == BUSY) && bus.fu_done && !bus.flush;

   assign bus.req_ready = grant ? pick_grant : '0;
   assign bus.fu_start  = grant;
   assign bus.fu_tag    = grant ? bus.req_tag[pick_idx] : '0;
   assign bus.fu_src    = grant ? pick_idx : '0;
   assign bus.res_valid = res_valid_q;
   assign bus.res_tag   = res_tag_q;
   assign bus.busy      = (state_q != IDLE);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (grant) state_d = BUSY;
         BUSY: begin
            if (bus.flush)        state_d = bus.fu_done ? IDLE : DRAIN;
            else if (bus.fu_done) state_d = grant ? BUSY : IDLE;
         end
         DRAIN:   if (bus.fu_done) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values; res_tag_q below relies on the old held_tag_q.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= IDLE;
         rr_ptr_q    <= '0;
         held_tag_q  <= '0;
         res_valid_q <= 1'b0;
         res_tag_q   <= '0;
      end else begin
         state_q     <= state_d;
         res_valid_q <= res_valid_d;
         if (res_valid_d) res_tag_q <= held_tag_q;
         if (grant) begin
            held_tag_q <= bus.req_tag[pick_idx];
            rr_ptr_q   <= (pick_idx == IDX_W'(N-1)) ? '0 : pick_idx + IDX_W'(1);
         end
      end
   end

`ifdef FU_ARB_PERF_EN
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         perf_grant_cnt <= '0;
         perf_busy_cnt  <= '0;
      end else begin
         for (int i = 0; i < N; i++)
            if (grant && pick_grant[i]) perf_grant_cnt[i] <= sat_inc(perf_grant_cnt[i]);
         if (state_q != IDLE) perf_busy_cnt <= sat_inc(perf_busy_cnt);
      end
   end
`endif

   // A completion pulse with nothing in flight means the unit and arbiter disagree.
   a_no_done_in_idle: assert property (@(posedge clk) disable iff (!rstn)
      !(state_q == IDLE && bus.fu_done))
      else $error("fu_done asserted while arbiter IDLE");

endmodule
